frogger_game_ctrl: RTL and testbench

//  Game-flow sequencer for Frogger. Consumes per-row car/lilypad collision flags and frog Y position.

---
 rtl/frogger_game_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_frogger_game_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_game_ctrl.sv
// Frogger game-flow sequencer: lives, score, level, per-life timer, respawn
// pulses and motion freeze, all evaluated once per VGA frame.
// Optional feature: define FROGGER_HISCORE_EN to keep a best-score register.
//
//  state | meaning
//  IDLE  | waiting for Start, everything frozen
//  PLAY  | frog moving, collisions and timer evaluated per frame
//  DYING | frozen for DEATH_FRAMES after a death
//  WIN   | frozen for WIN_FRAMES after reaching the goal
//  OVER  | no lives left, Start returns to IDLE
module frogger_game_ctrl #(
  parameter int NUM_LIVES    = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 30,
  parameter int TIME_FRAMES  = 1800,
  parameter int GOAL_Y       = 40,
  parameter int RIVER_TOP    = 80,
  parameter int RIVER_BOT    = 240,
  parameter int GOAL_POINTS  = 10,
  parameter int MAX_LEVEL    = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        Start,
  input  logic [10:0] Frog_Y,
  input  logic [3:0]  Car_Collision,
  input  logic [3:0]  LPad_Collision,
  output logic        Frog_Reset,
  output logic        Freeze,
  output logic [2:0]  Game_State,
  output logic [1:0]  Death_Cause,
  output logic [2:0]  Lives,
  output logic [15:0] Score,
  output logic [2:0]  Level,
  output logic [11:0] Time_Left,
  output logic [15:0] Hi_Score
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_DYING = 3'd2,
    S_WIN   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [2:0]  LIVES_INIT  = 3'(NUM_LIVES);
  localparam logic [2:0]  LEVEL_MAX   = 3'(MAX_LEVEL);
  localparam logic [11:0] TIME_INIT   = 12'(TIME_FRAMES);
  localparam logic [11:0] DEATH_CNT   = 12'(DEATH_FRAMES);
  localparam logic [11:0] WIN_CNT     = 12'(WIN_FRAMES);
  localparam logic [10:0] GOAL_Y_C    = 11'(GOAL_Y);
  localparam logic [10:0] RIVER_TOP_C = 11'(RIVER_TOP);
  localparam logic [10:0] RIVER_BOT_C = 11'(RIVER_BOT);
  localparam logic [16:0] GOAL_PTS    = 17'(GOAL_POINTS);

  state_t      state;
  logic [2:0]  fsync;
  logic        tick;
  logic        start_q;
  logic        start_rise;
  logic [11:0] frz_cnt;
  logic        in_river;
  logic        at_goal;
  logic [1:0]  cause_now;
  logic [16:0] score_sum;
  logic [15:0] score_next;

  assign Game_State = state;
  assign start_rise = Start & ~start_q;
  assign in_river   = (Frog_Y >= RIVER_TOP_C) && (Frog_Y < RIVER_BOT_C);
  assign at_goal    = Frog_Y < GOAL_Y_C;
  assign score_sum  = {1'b0, Score} + GOAL_PTS;
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Death checks in priority order: car, drown, timeout.
  always_comb begin
    cause_now = 2'd0;
    if (|Car_Collision)                      cause_now = 2'd1;
    else if (in_river && ~|LPad_Collision)   cause_now = 2'd2;
    else if (Time_Left == 12'd0)             cause_now = 2'd3;
  end

  // Synchronise vsync, make a one-cycle frame tick, and edge-detect Start.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsync   <= 3'b000;
      tick    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      fsync   <= {fsync[1:0], frame_clk};
      tick    <= fsync[1] & ~fsync[2];
      start_q <= Start;
    end
  end

`ifdef FROGGER_HISCORE_EN
  logic [15:0] hi_score_q;
  assign Hi_Score = hi_score_q;
`else
  assign Hi_Score = 16'h0000;
`endif

  // Game FSM with registered outputs; Freeze tracks every state change.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      Freeze      <= 1'b1;
      Frog_Reset  <= 1'b0;
      Death_Cause <= 2'd0;
      Lives       <= 3'd0;
      Score       <= 16'd0;
      Level       <= 3'd0;
      Time_Left   <= 12'd0;
      frz_cnt     <= 12'd0;
`ifdef FROGGER_HISCORE_EN
      hi_score_q  <= 16'd0;
`endif
    end else begin
      Frog_Reset <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            state       <= S_PLAY;
            Freeze      <= 1'b0;
            Frog_Reset  <= 1'b1;
            Lives       <= LIVES_INIT;
            Score       <= 16'd0;
            Level       <= 3'd0;
            Time_Left   <= TIME_INIT;
            Death_Cause <= 2'd0;
          end
        end
        S_PLAY: begin
          if (tick) begin
            if (cause_now != 2'd0) begin
              state       <= S_DYING;
              Freeze      <= 1'b1;
              Death_Cause <= cause_now;
              frz_cnt     <= DEATH_CNT;
              if (Lives != 3'd0) Lives <= Lives - 3'd1;
            end else if (at_goal) begin
              state   <= S_WIN;
              Freeze  <= 1'b1;
              Score   <= score_next;
              frz_cnt <= WIN_CNT;
              if (Level < LEVEL_MAX) Level <= Level + 3'd1;
            end else begin
              Time_Left <= Time_Left - 12'd1;
            end
          end
        end
        S_DYING, S_WIN: begin
          // Leave on the tick that would take the counter to zero, so the
          // freeze lasts exactly the loaded number of frames.
          if (tick) begin
            if (frz_cnt > 12'd1) begin
              frz_cnt <= frz_cnt - 12'd1;
            end else if (state == S_DYING && Lives == 3'd0) begin
              state   <= S_OVER;
              frz_cnt <= 12'd0;
`ifdef FROGGER_HISCORE_EN
              if (Score > hi_score_q) hi_score_q <= Score;
`endif
            end else begin
              state       <= S_PLAY;
              Freeze      <= 1'b0;
              Frog_Reset  <= 1'b1;
              Time_Left   <= TIME_INIT;
              Death_Cause <= 2'd0;
              frz_cnt     <= 12'd0;
            end
          end
        end
        S_OVER: begin
          if (start_rise) state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          Freeze <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Self-checking bench for frogger_game_ctrl: directed scenarios, randomized
// play against a frame-level behavioural model, and a short-timer instance
// for the game-over-by-timeout path.
module tb_frogger_game_ctrl;

  localparam int P_LIVES = 3;
  localparam int P_DEATH = 60;
  localparam int P_WIN   = 30;
  localparam int P_TIME  = 1800;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, Start;
  logic [10:0] Frog_Y;
  logic [3:0]  Car_Collision, LPad_Collision;

  logic        Frog_Reset, Freeze;
  logic [2:0]  Game_State, Lives, Level;
  logic [1:0]  Death_Cause;
  logic [15:0] Score, Hi_Score;
  logic [11:0] Time_Left;

  logic        t_Frog_Reset, t_Freeze;
  logic [2:0]  t_Game_State, t_Lives, t_Level;
  logic [1:0]  t_Death_Cause;
  logic [15:0] t_Score, t_Hi_Score;
  logic [11:0] t_Time_Left;

  frogger_game_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Start(Start),
    .Frog_Y(Frog_Y), .Car_Collision(Car_Collision), .LPad_Collision(LPad_Collision),
    .Frog_Reset(Frog_Reset), .Freeze(Freeze), .Game_State(Game_State),
    .Death_Cause(Death_Cause), .Lives(Lives), .Score(Score), .Level(Level),
    .Time_Left(Time_Left), .Hi_Score(Hi_Score)
  );

  frogger_game_ctrl #(.TIME_FRAMES(2)) dut_t (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Start(Start),
    .Frog_Y(Frog_Y), .Car_Collision(Car_Collision), .LPad_Collision(LPad_Collision),
    .Frog_Reset(t_Frog_Reset), .Freeze(t_Freeze), .Game_State(t_Game_State),
    .Death_Cause(t_Death_Cause), .Lives(t_Lives), .Score(t_Score), .Level(t_Level),
    .Time_Left(t_Time_Left), .Hi_Score(t_Hi_Score)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int fr_seen = 0;
  int fr_exp = 0;

  // Model of the game, advanced once per frame: 0 idle, 1 play, 2 dying, 3 win, 4 over.
  int m_state, m_lives, m_score, m_level, m_time, m_left, m_cause, m_hi;

  always @(negedge Clk) if (Frog_Reset === 1'b1) fr_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_level = 0;
    m_time = 0; m_left = 0; m_cause = 0; m_hi = 0;
  endtask

  task automatic model_start();
    if (m_state == 0) begin
      m_state = 1; m_lives = P_LIVES; m_score = 0; m_level = 0;
      m_time = P_TIME; m_cause = 0; fr_exp++;
    end else if (m_state == 4) begin
      m_state = 0;
    end
  endtask

  task automatic model_frame(input int y, input int car, input int lpad);
    bit river;
    river = (y >= 80) && (y < 240);
    case (m_state)
      1: begin
        if (car != 0)                 m_cause = 1;
        else if (river && lpad == 0)  m_cause = 2;
        else if (m_time == 0)         m_cause = 3;
        if (m_cause != 0) begin
          m_state = 2;
          m_left  = P_DEATH;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (y < 40) begin
          m_state = 3;
          m_left  = P_WIN;
          m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
          m_level = (m_level + 1 > 7) ? 7 : m_level + 1;
        end else begin
          m_time = m_time - 1;
        end
      end
      2, 3: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_state == 2 && m_lives == 0) begin
            m_state = 4;
            if (m_score > m_hi) m_hi = m_score;
          end else begin
            m_state = 1; m_time = P_TIME; m_cause = 0; fr_exp++;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(Game_State), m_state);
    check({tag, ".freeze"}, 32'(Freeze), (m_state != 1) ? 1 : 0);
    check({tag, ".lives"}, 32'(Lives), m_lives);
    check({tag, ".score"}, 32'(Score), m_score);
    check({tag, ".level"}, 32'(Level), m_level);
    check({tag, ".time"}, 32'(Time_Left), m_time);
    check({tag, ".cause"}, 32'(Death_Cause), m_cause);
`ifdef FROGGER_HISCORE_EN
    check({tag, ".hi"}, 32'(Hi_Score), m_hi);
`else
    check({tag, ".hi"}, 32'(Hi_Score), 0);
`endif
    check({tag, ".respawns"}, fr_seen, fr_exp);
  endtask

  task automatic frame(input int y, input int car, input int lpad);
    @(negedge Clk);
    Frog_Y = 11'(y); Car_Collision = 4'(car); LPad_Collision = 4'(lpad);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
    model_frame(y, car, lpad);
    check_all("frame");
  endtask

  task automatic frames_quiet(input int n);
    for (int i = 0; i < n; i++) frame(300, 0, 0);
  endtask

  task automatic start_pulse(input int n);
    @(negedge Clk);
    Start = 1'b1;
    repeat (n) @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    model_start();
    check_all("start");
  endtask

  task automatic reset_pulse();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    model_reset();
    check_all("reset");
  endtask

  task automatic check_t(input string tag, input int st, input int lv, input int tl, input int cause);
    check({tag, ".state"}, 32'(t_Game_State), st);
    check({tag, ".lives"}, 32'(t_Lives), lv);
    check({tag, ".time"}, 32'(t_Time_Left), tl);
    check({tag, ".cause"}, 32'(t_Death_Cause), cause);
    check({tag, ".freeze"}, 32'(t_Freeze), (st != 1) ? 1 : 0);
  endtask

  initial begin
    int ys [10] = '{20, 39, 40, 79, 80, 100, 200, 239, 240, 300};
    int y, car, lpad;

    Reset = 1'b1; Start = 1'b0; frame_clk = 1'b0;
    Frog_Y = 11'd300; Car_Collision = 4'd0; LPad_Collision = 4'd0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_all("in_reset");
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Held Start gives exactly one game start and one respawn pulse.
    start_pulse(100);
    check("start_time", 32'(Time_Left), 1800);
    frames_quiet(1);
    frame(100, 0, 4'b0001);
    frame(300, 4'b0100, 0);
    check("car_cause", 32'(Death_Cause), 1);
    frames_quiet(59);
    check("still_dying", 32'(Game_State), 2);
    frames_quiet(1);
    check("respawned", 32'(Game_State), 1);
    frame(100, 0, 0);
    check("drown_cause", 32'(Death_Cause), 2);
    frames_quiet(60);
    frame(20, 0, 0);
    check("win_score", 32'(Score), 10);
    frames_quiet(30);
    frame(20, 1, 0);
    check("death_beats_goal", 32'(Game_State), 2);
    frames_quiet(60);
    check("game_over", 32'(Game_State), 4);
    start_pulse(3);
    check("over_to_idle", 32'(Game_State), 0);
    start_pulse(3);

    // Reset in the middle of a death freeze.
    frame(300, 4'b0010, 0);
    frames_quiet(5);
    reset_pulse();
    frames_quiet(2);

    // Randomized play against the model.
    start_pulse(2);
    for (int i = 0; i < 600; i++) begin
      if ((m_state == 0 || m_state == 4) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 15) == 0))
        start_pulse($urandom_range(1, 4));
      y    = ys[$urandom_range(0, 9)];
      car  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 0;
      lpad = $urandom_range(0, 15);
      frame(y, car, lpad);
    end

    // Short-timer instance: a goal, then three timeouts to game over.
    reset_pulse();
    start_pulse(3);
    check_t("t_start", 1, 3, 2, 0);
    frame(20, 0, 0);
    check("t_win_score", 32'(t_Score), 10);
    frames_quiet(30);
    check_t("t_after_win", 1, 3, 2, 0);
    for (int k = 1; k <= 3; k++) begin
      frames_quiet(2);
      check_t("t_zero", 1, 4 - k, 0, 0);
      frames_quiet(1);
      check_t("t_timeout", 2, 3 - k, 0, 3);
      frames_quiet(60);
      if (k < 3) check_t("t_resume", 1, 3 - k, 2, 0);
    end
    check_t("t_over", 4, 0, 0, 3);
`ifdef FROGGER_HISCORE_EN
    check("t_hi", 32'(t_Hi_Score), 10);
`else
    check("t_hi", 32'(t_Hi_Score), 0);
`endif
    start_pulse(2);
    check("t_idle", 32'(t_Game_State), 0);
    check("t_idle_freeze", 32'(t_Freeze), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
